// File: rtl/marcador_puntaje.sv
// -----------------------------------------------------------------------------
// marcador_puntaje
//   Score keeper for the reaction game. It turns the control FSM's score-modify
//   strobes into one add/subtract per rising edge, keeps both players' scores,
//   flags the winner back to the FSM and scans both scores onto a 4-digit
//   multiplexed 7-segment display.
//
// Ports
//   clock      in   system clock, all state on rising edge
//   Reset      in   synchronous, active-high reset
//   Modo       in   1 = add point, 0 = subtract point (sampled with the edge)
//   ModifA/B   in   modify strobe for player A/B (level, may last >1 cycle)
//   PuntajeA/B out  7-bit binary score of player A/B (registered)
//   GanadorA/B out  player A/B reached WIN_SCORE, held until Reset
//   Segmentos  out  active-low segments, bit0 = a ... bit6 = g
//   Anodos     out  active-low one-hot digit enable
//                   [3] A tens, [2] A units, [1] B tens, [0] B units
// -----------------------------------------------------------------------------
module marcador_puntaje #(
   parameter int WIN_SCORE  = 10,
   parameter int INIT_SCORE = 0,
   parameter int SCAN_BITS  = 16
) (
   input  logic       clock,
   input  logic       Reset,
   input  logic       Modo,
   input  logic       ModifA,
   input  logic       ModifB,
   output logic [6:0] PuntajeA,
   output logic [6:0] PuntajeB,
   output logic       GanadorA,
   output logic       GanadorB,
   output logic [6:0] Segmentos,
   output logic [3:0] Anodos
);

   localparam logic [6:0] WIN7  = 7'(WIN_SCORE);
   localparam logic [6:0] INIT7 = 7'(INIT_SCORE);

   typedef enum logic {
      JUEGO,
      FIN
   } state_e;

   state_e               state_q;
   logic                 modif_a_q, modif_b_q;
   logic [6:0]           punt_a_q, punt_b_q;
   logic                 gan_a_q, gan_b_q;
   logic [SCAN_BITS-1:0] scan_q;
   logic [1:0]           dig_q;
   logic [6:0]           seg_q;
   logic [3:0]           an_q;

   logic                 ev_a, ev_b;
   logic [6:0]           punt_a_d, punt_b_d;
   logic [SCAN_BITS-1:0] scan_d;
   logic [1:0]           dig_d;

   // Apply one event to a score. Adds stop at WIN_SCORE, subtracts stop at 0.
   function automatic logic [6:0] step(input logic [6:0] s, input logic ev,
                                       input logic add);
      if (!ev)  return s;
      if (add)  return (s < WIN7) ? s + 7'd1 : s;
      return (s == 7'd0) ? s : s - 7'd1;
   endfunction

   function automatic logic [6:0] seg_enc(input logic [6:0] d);
      case (d)
         7'd0:    return 7'h40;
         7'd1:    return 7'h79;
         7'd2:    return 7'h24;
         7'd3:    return 7'h30;
         7'd4:    return 7'h19;
         7'd5:    return 7'h12;
         7'd6:    return 7'h02;
         7'd7:    return 7'h78;
         7'd8:    return 7'h00;
         7'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Segment pattern for digit index idx: 0/1 = A tens/units, 2/3 = B tens/units.
   // A leading zero in the tens position is blanked.
   function automatic logic [6:0] digit_pattern(input logic [1:0] idx,
                                                input logic [6:0] a,
                                                input logic [6:0] b);
      logic [6:0] s;
      logic [6:0] tens, units;
      s     = idx[1] ? b : a;
      tens  = s / 7'd10;
      units = s % 7'd10;
      if (!idx[0]) return (tens == 7'd0) ? 7'h7F : seg_enc(tens);
      return seg_enc(units);
   endfunction

   function automatic logic [3:0] anode(input logic [1:0] idx);
      return ~(4'b1000 >> idx);
   endfunction

   // NOTE: every signal written here gets a value on every path, otherwise
   // synthesis would infer a latch to hold the old value.
   always_comb begin
      ev_a = ModifA & ~modif_a_q;
      ev_b = ModifB & ~modif_b_q;
      if (state_q == JUEGO) begin
         punt_a_d = step(punt_a_q, ev_a, Modo);
         punt_b_d = step(punt_b_q, ev_b, Modo);
      end else begin
         punt_a_d = punt_a_q;
         punt_b_d = punt_b_q;
      end
      scan_d = scan_q + SCAN_BITS'(1);
      dig_d  = (&scan_q) ? dig_q + 2'd1 : dig_q;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q   <= JUEGO;
         modif_a_q <= 1'b0;
         modif_b_q <= 1'b0;
         punt_a_q  <= INIT7;
         punt_b_q  <= INIT7;
         gan_a_q   <= 1'b0;
         gan_b_q   <= 1'b0;
         scan_q    <= '0;
         dig_q     <= 2'd0;
         seg_q     <= digit_pattern(2'd0, INIT7, INIT7);
         an_q      <= anode(2'd0);
      end else begin
         modif_a_q <= ModifA;
         modif_b_q <= ModifB;
         scan_q    <= scan_d;
         dig_q     <= dig_d;
         // Display is built from next-state index and scores so the digit
         // enable and its segments change on the same edge.
         seg_q     <= digit_pattern(dig_d, punt_a_d, punt_b_d);
         an_q      <= anode(dig_d);
         case (state_q)
            JUEGO: begin
               punt_a_q <= punt_a_d;
               punt_b_q <= punt_b_d;
               // Winner flags rise on the same edge the score reaches WIN_SCORE.
               if (punt_a_d == WIN7) gan_a_q <= 1'b1;
               if (punt_b_d == WIN7) gan_b_q <= 1'b1;
               if (punt_a_d == WIN7 || punt_b_d == WIN7) state_q <= FIN;
            end
            FIN: begin
               // Frozen until Reset.
            end
            default: state_q <= JUEGO;
         endcase
      end
   end

   assign PuntajeA  = punt_a_q;
   assign PuntajeB  = punt_b_q;
   assign GanadorA  = gan_a_q;
   assign GanadorB  = gan_b_q;
   assign Segmentos = seg_q;
   assign Anodos    = an_q;

endmodule
